// File: rtl/phase_shift_oscillator.sv
// Digitally controlled oscillator: divides clk_i by DIV_N and applies single-cycle
// phase corrections (advance/retard) requested by the loop filter.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no correction pending; period runs nominal (DIV_N cycles)
// ADV   | advance pending; wraps at DIV_N-2, shortening one period
// RET   | retard pending; wraps at DIV_N, lengthening one period
module phase_shift_oscillator #(
   parameter int DIV_N = 16,
   parameter int CNT_W = $clog2(DIV_N + 1)
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic positiveShift_i,
   input  logic negativeShift_i,
   output logic recoveredClk_o,
   output logic phaseTick_o,
   output logic shiftApplied_o,
   output logic shiftDropped_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADV  = 2'd1,
      S_RET  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TC_ADV = CNT_W'(DIV_N - 2);
   localparam logic [CNT_W-1:0] TC_NOM = CNT_W'(DIV_N - 1);
   localparam logic [CNT_W-1:0] TC_EXT = CNT_W'(DIV_N);
   localparam logic [CNT_W-1:0] HALF   = CNT_W'(DIV_N / 2);

   state_t           r_state;
   state_t           w_state_next;
   state_t           w_state_base;
   logic [CNT_W-1:0] r_phase;
   logic [CNT_W-1:0] w_phase_next;
   logic             w_apply_adv;
   logic             w_apply_ret;
   logic             w_drop;
   logic             w_pos_only;
   logic             w_neg_only;

   logic r_clk;
   logic r_tick;
   logic r_applied;
   logic r_dropped;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state   <= S_IDLE;
         r_phase   <= '0;
         r_clk     <= 1'b1;
         r_tick    <= 1'b0;
         r_applied <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_phase   <= w_phase_next;
         r_clk     <= (w_phase_next < HALF);
         r_tick    <= (w_phase_next == '0);
         r_applied <= w_apply_adv | w_apply_ret;
         r_dropped <= w_drop;
      end
   end

   always_comb begin
      w_pos_only   = positiveShift_i & ~negativeShift_i;
      w_neg_only   = negativeShift_i & ~positiveShift_i;
      w_apply_adv  = (r_state == S_ADV) && (r_phase == TC_ADV);
      w_apply_ret  = (r_state == S_RET) && (r_phase == TC_NOM);
      w_drop       = 1'b0;
      // An applied correction frees the FSM so a same-cycle request is taken as from IDLE.
      w_state_base = (w_apply_adv || w_apply_ret) ? S_IDLE : r_state;
      w_state_next = w_state_base;

      case (w_state_base)
         S_IDLE: begin
            if (w_pos_only)      w_state_next = S_ADV;
            else if (w_neg_only) w_state_next = S_RET;
         end
         S_ADV: begin
            if (w_neg_only)      w_state_next = S_IDLE;
            else if (w_pos_only) w_drop       = 1'b1;
         end
         S_RET: begin
            if (w_pos_only)      w_state_next = S_IDLE;
            else if (w_neg_only) w_drop       = 1'b1;
         end
         default: w_state_next = S_IDLE;
      endcase

      if (w_apply_adv)           w_phase_next = '0;
      else if (w_apply_ret)      w_phase_next = TC_EXT;
      else if (r_phase >= TC_NOM) w_phase_next = '0;
      else                       w_phase_next = r_phase + CNT_W'(1);
   end

   assign recoveredClk_o = r_clk;
   assign phaseTick_o    = r_tick;
   assign shiftApplied_o = r_applied;
   assign shiftDropped_o = r_dropped;

endmodule

// File: tb/tb_phase_shift_oscillator.sv
// Directed bench for phase_shift_oscillator at DIV_N=8: period lengths, high-phase
// length, correction/drop pulses and reset behaviour.
module tb_phase_shift_oscillator;

   logic clk_i = 1'b0;
   logic reset_i = 1'b0;
   logic positiveShift_i = 1'b0;
   logic negativeShift_i = 1'b0;
   logic recoveredClk_o;
   logic phaseTick_o;
   logic shiftApplied_o;
   logic shiftDropped_o;

   int n_tests = 0;
   int n_fail  = 0;

   int since_tick  = 0;
   int hi_acc      = 0;
   int last_period = 0;
   int last_hi     = 0;
   int applied_acc = 0;
   int dropped_acc = 0;

   phase_shift_oscillator #(.DIV_N(8)) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .positiveShift_i (positiveShift_i),
      .negativeShift_i (negativeShift_i),
      .recoveredClk_o  (recoveredClk_o),
      .phaseTick_o     (phaseTick_o),
      .shiftApplied_o  (shiftApplied_o),
      .shiftDropped_o  (shiftDropped_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input int obs, input int exp, input string tag);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Hold requests for one edge, then observe the post-edge outputs.
   task automatic cycle(input logic p, input logic n);
      positiveShift_i = p;
      negativeShift_i = n;
      @(posedge clk_i);
      #1;
      positiveShift_i = 1'b0;
      negativeShift_i = 1'b0;
      applied_acc += int'(shiftApplied_o);
      dropped_acc += int'(shiftDropped_o);
      if (phaseTick_o) begin
         last_period = since_tick;
         last_hi     = hi_acc;
         since_tick  = 1;
         hi_acc      = int'(recoveredClk_o);
      end else begin
         since_tick++;
         hi_acc += int'(recoveredClk_o);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
   endtask

   task automatic finish_period(input int exp_len, input int exp_hi, input string tag);
      int got;
      got = 0;
      for (int i = 0; i < 20 && got == 0; i++) begin
         cycle(1'b0, 1'b0);
         if (phaseTick_o) got = 1;
      end
      check(got, 1, {tag, "_tick"});
      check(last_period, exp_len, {tag, "_period"});
      check(last_hi, exp_hi, {tag, "_high"});
   endtask

   task automatic clear_counts();
      applied_acc = 0;
      dropped_acc = 0;
   endtask

   initial begin
      // Reset values
      #23;
      check(int'(recoveredClk_o), 1, "rst_clk");
      check(int'(phaseTick_o), 0, "rst_tick");
      check(int'(shiftApplied_o), 0, "rst_applied");
      check(int'(shiftDropped_o), 0, "rst_dropped");
      reset_i    = 1'b1;
      since_tick = 1;
      hi_acc     = 1;

      // First tick 8 edges after release, then nominal periods
      finish_period(8, 4, "first");
      finish_period(8, 4, "nom1");
      clear_counts();

      // Advance sampled at phase 2
      idle(2);
      cycle(1'b1, 1'b0);
      finish_period(7, 4, "adv2");
      check(int'(shiftApplied_o), 1, "adv2_applied_at_wrap");
      check(applied_acc, 1, "adv2_applied_cnt");
      finish_period(8, 4, "adv2_after");
      check(dropped_acc, 0, "adv2_dropped_cnt");
      clear_counts();

      // Retard sampled at phase 2
      idle(2);
      cycle(1'b0, 1'b1);
      finish_period(9, 4, "ret2");
      check(applied_acc, 1, "ret2_applied_cnt");
      finish_period(8, 4, "ret2_after");
      clear_counts();

      // Advance sampled at phase 6 lands in the next period
      idle(6);
      cycle(1'b1, 1'b0);
      finish_period(8, 4, "adv6_cur");
      check(applied_acc, 0, "adv6_cur_applied");
      finish_period(7, 4, "adv6_next");
      check(applied_acc, 1, "adv6_applied_cnt");
      clear_counts();

      // Both requests together: net zero
      idle(2);
      cycle(1'b1, 1'b1);
      finish_period(8, 4, "both");
      check(applied_acc + dropped_acc, 0, "both_pulses");
      clear_counts();

      // Pos at 1 cancelled by neg at 3
      idle(1);
      cycle(1'b1, 1'b0);
      idle(1);
      cycle(1'b0, 1'b1);
      finish_period(8, 4, "cancel");
      check(applied_acc, 0, "cancel_applied");
      check(dropped_acc, 0, "cancel_dropped");
      clear_counts();

      // Pos at 1 and 3: second is dropped, pulse visible in phase-4 cycle
      idle(1);
      cycle(1'b1, 1'b0);
      idle(1);
      cycle(1'b1, 1'b0);
      check(int'(shiftDropped_o), 1, "drop_pos_phase4");
      finish_period(7, 4, "drop_pos");
      check(dropped_acc, 1, "drop_pos_cnt");
      check(applied_acc, 1, "drop_pos_applied");
      finish_period(8, 4, "drop_pos_after");
      clear_counts();

      // Retard sampled at phase 7 lengthens the next period
      idle(7);
      cycle(1'b0, 1'b1);
      check(int'(phaseTick_o), 1, "ret7_wrap_tick");
      check(last_period, 8, "ret7_cur_period");
      finish_period(9, 4, "ret7_next");
      check(applied_acc, 1, "ret7_applied_cnt");
      clear_counts();

      // Neg at 1 and 3: second retard dropped
      idle(1);
      cycle(1'b0, 1'b1);
      idle(1);
      cycle(1'b0, 1'b1);
      check(int'(shiftDropped_o), 1, "drop_neg_phase4");
      finish_period(9, 4, "drop_neg");
      check(dropped_acc, 1, "drop_neg_cnt");
      clear_counts();

      // Pending retard, reset asserted at phase 5
      idle(2);
      cycle(1'b0, 1'b1);
      idle(2);
      check(int'(recoveredClk_o), 0, "pre_rst_clk_low");
      reset_i = 1'b0;
      #1;
      check(int'(recoveredClk_o), 1, "midrst_clk");
      check(int'(phaseTick_o), 0, "midrst_tick");
      check(int'(shiftApplied_o), 0, "midrst_applied");
      check(int'(shiftDropped_o), 0, "midrst_dropped");
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      reset_i    = 1'b1;
      since_tick = 1;
      hi_acc     = 1;
      clear_counts();
      finish_period(8, 4, "post_rst");
      check(applied_acc, 0, "post_rst_applied");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
